// File: rtl/ccc_rst_seq_pkg.sv
// Shared types and constants for the CCC lock-driven fabric reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ccc_rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int                    LOSS_CNT_W   = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous CCC lock into the PCLK domain.
// Latency: SYNC_STAGES clock edges from input change to output change.
// Backpressure: none; free-running, cleared to 0 by the asynchronous reset.
module ccc_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_lock,
    output logic lock_s
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw lock through the flop chain; bit 0 is the metastability catcher.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_lock};
        end
    end

    assign lock_s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Staged fabric reset release gated by a stable, synchronized CCC lock (loss counter under CCC_RST_SEQ_LOSS_CNT_EN).
// Latency: lock_in->lock_s SYNC_STAGES edges; lock_s rise->stage 0 LOCK_STABLE_CYCLES+1; stage gaps STAGE_GAP_CYCLES.
// Backpressure: none; lock loss drops all resets one edge after lock_s falls and overrides software restart.
module ccc_lock_reset_seq
    import ccc_rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int NUM_STAGES         = 3,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    input  logic                  lock_in,
    input  logic                  sw_reset_req,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [1:0]            state
);

    // A 1-cycle stabilization window still needs a 1-bit counter to exist.
    localparam int STAB_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int GAP_W  = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;
    localparam int STG_W  = $clog2(NUM_STAGES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_ALL   = STG_W'(NUM_STAGES);

    logic                  lock_s;
    seq_state_e            cur_st;
    seq_state_e            nxt_st;
    logic [STAB_W-1:0]     stab_cnt;
    logic [STAB_W-1:0]     stab_nxt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_nxt;
    logic [STG_W-1:0]      stage;
    logic [STG_W-1:0]      stage_nxt;
    logic [NUM_STAGES-1:0] rst_nxt;
    logic                  ready_nxt;

    ccc_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk        (PCLK),
        .rst_n      (PRESERN),
        .async_lock (lock_in),
        .lock_s     (lock_s)
    );

    // Next-state, counters and reset vector; counters default to 0 so any state exit clears them.
    always_comb begin
        nxt_st    = cur_st;
        stab_nxt  = '0;
        gap_nxt   = '0;
        stage_nxt = stage;
        rst_nxt   = rst_n_out;
        unique case (cur_st)
            WAIT_LOCK: begin
                rst_nxt   = '0;
                stage_nxt = '0;
                if (lock_s) begin
                    nxt_st = STABILIZE;
                end
            end
            STABILIZE: begin
                rst_nxt   = '0;
                stage_nxt = '0;
                if (!lock_s) begin
                    nxt_st = WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    nxt_st    = RELEASE;
                    rst_nxt   = NUM_STAGES'(1);
                    stage_nxt = STG_W'(1);
                end else begin
                    stab_nxt = stab_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!lock_s) begin
                    nxt_st    = WAIT_LOCK;
                    rst_nxt   = '0;
                    stage_nxt = '0;
                end else if (sw_reset_req) begin
                    // Restart from stage 0; it reopens one full gap later.
                    nxt_st    = RELEASE;
                    rst_nxt   = '0;
                    stage_nxt = '0;
                end else if (stage == STG_ALL) begin
                    nxt_st = RUN;
                end else if (gap_cnt == GAP_LAST) begin
                    rst_nxt   = rst_n_out | (NUM_STAGES'(1) << stage);
                    stage_nxt = stage + 1'b1;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    nxt_st    = WAIT_LOCK;
                    rst_nxt   = '0;
                    stage_nxt = '0;
                end else if (sw_reset_req) begin
                    nxt_st    = RELEASE;
                    rst_nxt   = '0;
                    stage_nxt = '0;
                end
            end
            default: begin
                nxt_st    = WAIT_LOCK;
                rst_nxt   = '0;
                stage_nxt = '0;
            end
        endcase
        ready_nxt = (nxt_st == RUN);
    end

    // State, counters and registered reset/ready outputs.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cur_st    <= WAIT_LOCK;
            stab_cnt  <= '0;
            gap_cnt   <= '0;
            stage     <= '0;
            rst_n_out <= '0;
            ready     <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            stab_cnt  <= stab_nxt;
            gap_cnt   <= gap_nxt;
            stage     <= stage_nxt;
            rst_n_out <= rst_nxt;
            ready     <= ready_nxt;
        end
    end

    assign state = cur_st;

`ifdef CCC_RST_SEQ_LOSS_CNT_EN
    logic                  loss_evt;
    logic [LOSS_CNT_W-1:0] loss_cnt;

    // Only a loss after release has begun counts; dropouts while stabilizing do not.
    assign loss_evt = ((cur_st == RELEASE) || (cur_st == RUN)) && !lock_s;

    // Saturating lock-loss counter.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            loss_cnt <= '0;
        end else if (loss_evt && (loss_cnt != LOSS_CNT_MAX)) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end

    assign lock_loss_count = loss_cnt;
`else
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: directed scenarios plus randomized lock/sw_reset traffic against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ccc_lock_reset_seq;

    localparam int L = 8;
    localparam int G = 4;
    localparam int N = 3;
    localparam int S = 2;

    logic         PCLK = 1'b0;
    logic         PRESERN;
    logic         lock_in;
    logic         sw_reset_req;
    logic [N-1:0] rst_n_out;
    logic         ready;
    logic [7:0]   lock_loss_count;
    logic [1:0]   state;

    int tests = 0;
    int fails = 0;
    int loss_seen = 0;

    ccc_lock_reset_seq #(
        .LOCK_STABLE_CYCLES (L),
        .STAGE_GAP_CYCLES   (G),
        .NUM_STAGES         (N),
        .SYNC_STAGES        (S)
    ) dut (
        .PCLK            (PCLK),
        .PRESERN         (PRESERN),
        .lock_in         (lock_in),
        .sw_reset_req    (sw_reset_req),
        .rst_n_out       (rst_n_out),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    always #5 PCLK = ~PCLK;

    // Timeline model: stage k is open once cycle >= t0 + k*G, where t0 is the
    // cycle stage 0 opened (or is scheduled to reopen after a software restart).
    logic [S-1:0] m_sync = '0;
    logic         m_ls = 1'b0;
    int           cyc = 0;
    bit           armed = 1'b0;
    int           h = 0;
    int           t0 = 0;
    int           m_cnt = 0;
    logic [N-1:0] exp_rst = '0;
    logic         exp_ready = 1'b0;
    logic [1:0]   exp_state = 2'd0;
    logic [7:0]   exp_cnt = 8'd0;

    always begin
        @(posedge PCLK or negedge PRESERN);
        if (!PRESERN) begin
            m_sync = '0;
            armed  = 1'b0;
            h      = 0;
            t0     = 0;
            m_cnt  = 0;
            cyc    = 0;
        end else begin
            m_ls   = m_sync[S-1];
            m_sync = {m_sync[S-2:0], lock_in};
            cyc    = cyc + 1;
            if (!armed) begin
                if (m_ls) begin
                    h = h + 1;
                    if (h == L + 1) begin
                        armed = 1'b1;
                        t0    = cyc;
                        h     = 0;
                    end
                end else begin
                    h = 0;
                end
            end else if (!m_ls) begin
                armed = 1'b0;
                h     = 0;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end else if (sw_reset_req) begin
                t0 = cyc + G;
            end
        end
        for (int k = 0; k < N; k++) exp_rst[k] = armed && (cyc >= t0 + k * G);
        exp_ready = armed && (cyc >= t0 + (N - 1) * G + 1);
        exp_state = armed ? (exp_ready ? 2'd3 : 2'd2) : ((h > 0) ? 2'd1 : 2'd0);
`ifdef CCC_RST_SEQ_LOSS_CNT_EN
        exp_cnt = 8'(m_cnt);
`else
        exp_cnt = 8'd0;
`endif
    end

    function automatic logic [7:0] cnt_for(input int n);
`ifdef CCC_RST_SEQ_LOSS_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    task automatic tick;
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Let lock_in=0 propagate so the DUT sits idle in WAIT_LOCK.
    task automatic settle_low;
        lock_in = 1'b0;
        sw_reset_req = 1'b0;
        repeat (S + 3) tick();
    endtask

    task automatic wait_run;
        int n;
        n = 0;
        while (!ready && n < 60) begin
            tick();
            n++;
        end
        tests++;
        if (!ready) begin
            fails++;
            $display("FAIL wait_run: ready=%b after %0d cycles, required 1", ready, n);
        end
    endtask

    task automatic test_reset;
        PRESERN = 1'b0;
        lock_in = 1'b1;
        sw_reset_req = 1'b0;
        #1;
        tests++; if (rst_n_out !== 3'b000) begin fails++; $display("FAIL reset_rst: got %b required 000", rst_n_out); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", ready); end
        tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d required 0", state); end
        tests++; if (lock_loss_count !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d required 0", lock_loss_count); end
        repeat (30) tick();
        tests++; if (rst_n_out !== 3'b000 || state !== 2'd0) begin
            fails++; $display("FAIL reset_hold: rst=%b state=%0d required 000/0", rst_n_out, state);
        end
        lock_in = 1'b0;
        PRESERN = 1'b1;
        settle_low();
    endtask

    task automatic test_clean_lock;
        logic [N-1:0] e;
        settle_low();
        lock_in = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            e = {1'(k >= 19), 1'(k >= 15), 1'(k >= 11)};
            tests++;
            if (rst_n_out !== e || ready !== 1'(k >= 20)) begin
                fails++;
                $display("FAIL clean_lock k=%0d: rst=%b ready=%b required %b/%b", k, rst_n_out, ready, e, k >= 20);
            end
        end
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL clean_state: got %0d required 3", state); end
        tests++; if (lock_loss_count !== cnt_for(loss_seen)) begin
            fails++; $display("FAIL clean_cnt: got %0d required %0d", lock_loss_count, cnt_for(loss_seen));
        end
    endtask

    task automatic test_sw_reset;
        logic [N-1:0] e;
        wait_run();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        tests++;
        if (rst_n_out !== 3'b000 || state !== 2'd2 || ready !== 1'b0) begin
            fails++; $display("FAIL sw_first: rst=%b state=%0d ready=%b required 000/2/0", rst_n_out, state, ready);
        end
        for (int k = 2; k <= 16; k++) begin
            tick();
            e = {1'(k >= 13), 1'(k >= 9), 1'(k >= 5)};
            tests++;
            if (rst_n_out !== e || ready !== 1'(k >= 14)) begin
                fails++;
                $display("FAIL sw_seq k=%0d: rst=%b ready=%b required %b/%b", k, rst_n_out, ready, e, k >= 14);
            end
        end
        tests++; if (state !== 2'd3) begin fails++; $display("FAIL sw_state: got %0d required 3", state); end
    endtask

    task automatic test_sw_and_loss;
        wait_run();
        lock_in = 1'b0;
        tick();
        tick();
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        loss_seen++;
        tests++;
        if (state !== 2'd0 || rst_n_out !== 3'b000 || ready !== 1'b0 || lock_loss_count !== cnt_for(loss_seen)) begin
            fails++;
            $display("FAIL sw_loss: state=%0d rst=%b ready=%b cnt=%0d required 0/000/0/%0d",
                     state, rst_n_out, ready, lock_loss_count, cnt_for(loss_seen));
        end
        for (int k = 0; k < 15; k++) begin
            tick();
            tests++;
            if (rst_n_out !== 3'b000 || state !== 2'd0) begin
                fails++; $display("FAIL sw_loss_hold k=%0d: rst=%b state=%0d required 000/0", k, rst_n_out, state);
            end
        end
    endtask

    task automatic test_glitch;
        bit seen_zero;
        int n;
        settle_low();
        lock_in = 1'b1;
        repeat (5) tick();
        tests++; if (state !== 2'd1) begin fails++; $display("FAIL glitch_stab: state=%0d required 1", state); end
        lock_in = 1'b0;
        seen_zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (state == 2'd0) seen_zero = 1'b1;
            tests++; if (rst_n_out !== 3'b000) begin fails++; $display("FAIL glitch_rst: got %b required 000", rst_n_out); end
        end
        lock_in = 1'b1;
        n = 0;
        while (rst_n_out[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (state == 2'd0) seen_zero = 1'b1;
        end
        tests++; if (!seen_zero) begin fails++; $display("FAIL glitch_wait: state=%0d never 0, required 0", state); end
        tests++; if (n != 11) begin fails++; $display("FAIL glitch_restart: release after %0d cycles required 11", n); end
        tests++; if (lock_loss_count !== cnt_for(loss_seen)) begin
            fails++; $display("FAIL glitch_cnt: got %0d required %0d", lock_loss_count, cnt_for(loss_seen));
        end
    endtask

    task automatic test_loss_in_run;
        for (int i = 0; i < 300; i++) begin
            wait_run();
            lock_in = 1'b0;
            tick();
            tick();
            tests++;
            if (rst_n_out !== 3'b111 || ready !== 1'b1) begin
                fails++; $display("FAIL loss_early i=%0d: rst=%b ready=%b required 111/1", i, rst_n_out, ready);
            end
            tick();
            loss_seen++;
            tests++;
            if (rst_n_out !== 3'b000 || ready !== 1'b0 || state !== 2'd0 || lock_loss_count !== cnt_for(loss_seen)) begin
                fails++;
                $display("FAIL loss i=%0d: rst=%b ready=%b state=%0d cnt=%0d required 000/0/0/%0d",
                         i, rst_n_out, ready, state, lock_loss_count, cnt_for(loss_seen));
            end
            lock_in = 1'b1;
        end
    endtask

    task automatic test_preset_mid_release;
        settle_low();
        lock_in = 1'b1;
        repeat (12) tick();
        tests++; if (rst_n_out !== 3'b001) begin fails++; $display("FAIL preset_pre: rst=%b required 001", rst_n_out); end
        #2;
        PRESERN = 1'b0;
        #1;
        loss_seen = 0;
        tests++;
        if (rst_n_out !== 3'b000 || state !== 2'd0 || ready !== 1'b0 || lock_loss_count !== 8'd0) begin
            fails++;
            $display("FAIL preset: rst=%b state=%0d ready=%b cnt=%0d required 000/0/0/0",
                     rst_n_out, state, ready, lock_loss_count);
        end
        @(negedge PCLK);
        repeat (3) tick();
        tests++; if (rst_n_out !== 3'b000) begin fails++; $display("FAIL preset_hold: rst=%b required 000", rst_n_out); end
        PRESERN = 1'b1;
    endtask

    task automatic test_random;
        int run_left;
        run_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                lock_in  = ~lock_in;
                run_left = lock_in ? $urandom_range(1, 40) : $urandom_range(1, 5);
            end
            run_left--;
            sw_reset_req = (!sw_reset_req && $urandom_range(0, 24) == 0);
            tick();
            tests++;
            if (rst_n_out !== exp_rst || ready !== exp_ready || state !== exp_state || lock_loss_count !== exp_cnt) begin
                fails++;
                $display("FAIL random c=%0d: rst=%b ready=%b state=%0d cnt=%0d required %b/%b/%0d/%0d",
                         c, rst_n_out, ready, state, lock_loss_count, exp_rst, exp_ready, exp_state, exp_cnt);
            end
        end
        sw_reset_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_sw_reset();
        test_sw_and_loss();
        test_glitch();
        test_loss_in_run();
        test_preset_mid_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
